dual_issue_ctrl: RTL and testbench
==================================

Name: dual_issue_ctrl

Overview:
- Issue stage directly upstream of the register-fetch/forwarding stage and the even/odd execution pipes.
- Accepts one decoded instruction pair per handshake and routes each instruction to the even or odd slot by its pipe bit.
- Enforces dual-issue rules: structural conflict, intra-pair RAW/WAW, and RAW against in-flight producers via a per-register latency scoreboard.
- Emits registered even/odd slot fields, inserting NOPs while stalled.

Parameters:
- NUM_REGS, 128, architectural registers; 7-bit address.
- LAT_W, 4, width of the latency field and scoreboard counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decoded pair present
- in_ready  out  1  pair consumed at this edge
- flush  in  1  branch redirect; discards held pair and pending second instruction
- iN_full_instr  in  32  instruction word, for N in {0, 1}; i0 is older
- iN_pipe  in  1  0 = even, 1 = odd
- iN_reg_wr  in  1  writes reg_dst
- iN_reg_dst  in  7  destination register
- iN_latency  in  4  result latency, 1..7
- iN_ra, iN_rb, iN_rc  in  7 each  source addresses
- iN_use_ra, iN_use_rb, iN_use_rc  in  1 each  source valid
- ev_valid, od_valid  out  1  slot carries a real instruction
- ev_/od_ full_instr (32), reg_wr (1), reg_dst (7), latency (4), ra/rb/rc (7 each)  out  registered slot fields

Behaviour:
- Reset, synchronous: all outputs 0 (a NOP in both slots); all scoreboard counters 0; FSM in IDLE; in_ready = 0 during the reset cycle.
- Scoreboard: one LAT_W counter per register.
  - When a writer with latency L issues, cnt[rd] <= max(cnt[rd] - 1, L - 1).
  - Every other nonzero counter decrements by 1 each cycle.
  - A source is ready when its counter is 0; results at that point are covered by the forwarding network.
  - Writes to r0 are tracked like any other register.
- Instruction readiness: ready(i) = all used sources ready.
- Conflict(pair) holds when any of the following is true:
  - i0_pipe == i1_pipe
  - i0 writes rd and i1 reads rd
  - both write the same rd
- FSM states:
  - IDLE: pair held in the input register.
    - If !conflict and both ready: issue both, in_ready = 1, stay IDLE.
    - If conflict and i0 ready: issue i0 only, go to SECOND.
    - If i0 not ready: issue nothing and stall. i1 never issues before i0.
  - SECOND: issue i1 once ready, then in_ready = 1 and return to IDLE.
- Issue latency: slot outputs are registered one cycle after the issue decision. The scoreboard updates in the same edge.
- Hazard check within the pair: i1 sees i0's scoreboard update through an explicit bypass, i.e. the conflict rule, not through the counter.
- in_ready is high only on the cycle the last instruction of a pair issues.
- Slot without an instruction: valid = 0, reg_wr = 0, all other fields 0.
- flush:
  - Next edge: both slots become NOP, FSM returns to IDLE, in_ready = 1 (held pair dropped).
  - Scoreboard keeps counting; in-flight writers are not cancelled.
  - Flush beats issue when both occur in the same cycle.
- in_valid = 0: both slots NOP, FSM unchanged.

Decomposition:
- Shared package contents:
  - PIPE_EVEN / PIPE_ODD constants
  - FSM state enum (IDLE, SECOND)
  - Slot field-bundle typedef, reused by the RF/forwarding stage
  - Max latency constant (7)
- Sub-module: issue_scoreboard. Holds the 128 counters; takes two write-issue ports and six read ports; returns per-source ready.

Test Plan:
1. i0 = even add r3 <- r1,r2 (lat 2); i1 = odd load r5 <- r4 (lat 6); no hazards -> both slots valid in the next cycle, in_ready = 1, cnt[3] = 1, cnt[5] = 5.
2. Both instructions even -> cycle 1: ev = i0, od NOP; cycle 2: ev = i1; in_ready high only on cycle 2.
3. i0 writes r7 (lat 6); next pair reads r7 -> 5 NOP cycles, then issue on the 6th cycle; check counter values 5, 4, 3, 2, 1, 0.
4. Intra-pair RAW: i0 odd writes r9, i1 even reads r9 -> split issue; i1 also waits until cnt[9] = 0.
5. flush asserted while in SECOND -> next cycle both slots NOP, state IDLE, in_ready = 1; in-flight cnt keeps decrementing.
6. rst asserted mid-stall with cnt[7] = 3 -> after one edge all outputs 0, cnt all 0; first pair after reset issues immediately.

Source files
------------

// File: rtl/dual_issue_ctrl_pkg.sv
// Shared types and constants for the dual-issue stage and the RF/forwarding stage that consumes
// its slot bundles.
package dual_issue_ctrl_pkg;

  localparam int unsigned InstrW     = 32;
  localparam int unsigned RegAddrW   = 7;
  localparam int unsigned LatW       = 4;
  localparam int unsigned MaxLatency = 7;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

  typedef enum logic [0:0] {StIdle, StSecond} issue_state_e;

  typedef struct packed {
    logic                valid;
    logic [InstrW-1:0]   full_instr;
    logic                reg_wr;
    logic [RegAddrW-1:0] reg_dst;
    logic [LatW-1:0]     latency;
    logic [RegAddrW-1:0] ra;
    logic [RegAddrW-1:0] rb;
    logic [RegAddrW-1:0] rc;
  } slot_t;

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register result-latency scoreboard: a register is readable once its counter reaches zero.
// Two issue write ports, six source read ports.
module issue_scoreboard
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 128,
  parameter int unsigned LAT_W    = 4,
  localparam int unsigned AddrW   = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr0_en,
  input  logic [AddrW-1:0]      wr0_dst,
  input  logic [LAT_W-1:0]      wr0_lat,
  input  logic                  wr1_en,
  input  logic [AddrW-1:0]      wr1_dst,
  input  logic [LAT_W-1:0]      wr1_lat,
  input  logic [5:0][AddrW-1:0] rd_addr,
  output logic [5:0]            rd_ready
);

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];
  logic [LAT_W-1:0] hold0, hold1;

  // Cycles a new writer keeps its destination busy after the issue edge.
  function automatic logic [LAT_W-1:0] residual(input logic [LAT_W-1:0] lat);
    logic [LAT_W-1:0] l;
    l = (lat > LAT_W'(MaxLatency)) ? LAT_W'(MaxLatency) : lat;
    return (l == '0) ? '0 : l - LAT_W'(1);
  endfunction

  assign hold0 = residual(wr0_lat);
  assign hold1 = residual(wr1_lat);

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - LAT_W'(1);
      if (wr0_en && (wr0_dst == AddrW'(r)) && (hold0 > cnt_d[r])) cnt_d[r] = hold0;
      if (wr1_en && (wr1_dst == AddrW'(r)) && (hold1 > cnt_d[r])) cnt_d[r] = hold1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 6; k++) rd_ready[k] = (cnt_q[rd_addr[k]] == '0);
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue stage: routes an instruction pair to the even/odd pipes, splitting the pair on
// structural or intra-pair hazards and stalling on in-flight producers.
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 128,
  parameter int unsigned LAT_W    = 4,
  localparam int unsigned AddrW   = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [31:0]      i0_full_instr,
  input  logic             i0_pipe,
  input  logic             i0_reg_wr,
  input  logic [AddrW-1:0] i0_reg_dst,
  input  logic [LAT_W-1:0] i0_latency,
  input  logic [AddrW-1:0] i0_ra,
  input  logic [AddrW-1:0] i0_rb,
  input  logic [AddrW-1:0] i0_rc,
  input  logic             i0_use_ra,
  input  logic             i0_use_rb,
  input  logic             i0_use_rc,
  input  logic [31:0]      i1_full_instr,
  input  logic             i1_pipe,
  input  logic             i1_reg_wr,
  input  logic [AddrW-1:0] i1_reg_dst,
  input  logic [LAT_W-1:0] i1_latency,
  input  logic [AddrW-1:0] i1_ra,
  input  logic [AddrW-1:0] i1_rb,
  input  logic [AddrW-1:0] i1_rc,
  input  logic             i1_use_ra,
  input  logic             i1_use_rb,
  input  logic             i1_use_rc,
  output logic             ev_valid,
  output logic [31:0]      ev_full_instr,
  output logic             ev_reg_wr,
  output logic [AddrW-1:0] ev_reg_dst,
  output logic [LAT_W-1:0] ev_latency,
  output logic [AddrW-1:0] ev_ra,
  output logic [AddrW-1:0] ev_rb,
  output logic [AddrW-1:0] ev_rc,
  output logic             od_valid,
  output logic [31:0]      od_full_instr,
  output logic             od_reg_wr,
  output logic [AddrW-1:0] od_reg_dst,
  output logic [LAT_W-1:0] od_latency,
  output logic [AddrW-1:0] od_ra,
  output logic [AddrW-1:0] od_rb,
  output logic [AddrW-1:0] od_rc
);

  issue_state_e state_q, state_d;
  slot_t        ev_q, ev_d, od_q, od_d;
  slot_t        s0, s1;

  logic [5:0][AddrW-1:0] src_addr;
  logic [5:0]            src_ready;
  logic                  i0_rdy, i1_rdy;
  logic                  i1_reads_i0, waw, conflict;
  logic                  iss0, iss1, pair_done;

  assign src_addr = {i1_rc, i1_rb, i1_ra, i0_rc, i0_rb, i0_ra};

  issue_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .LAT_W   (LAT_W)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .wr0_en  (iss0 && i0_reg_wr),
    .wr0_dst (i0_reg_dst),
    .wr0_lat (i0_latency),
    .wr1_en  (iss1 && i1_reg_wr),
    .wr1_dst (i1_reg_dst),
    .wr1_lat (i1_latency),
    .rd_addr (src_addr),
    .rd_ready(src_ready)
  );

  assign i0_rdy = (!i0_use_ra || src_ready[0]) && (!i0_use_rb || src_ready[1]) &&
                  (!i0_use_rc || src_ready[2]);
  assign i1_rdy = (!i1_use_ra || src_ready[3]) && (!i1_use_rb || src_ready[4]) &&
                  (!i1_use_rc || src_ready[5]);

  // i0's scoreboard write is not yet visible to i1, so intra-pair RAW forces a split.
  assign i1_reads_i0 = i0_reg_wr && ((i1_use_ra && (i1_ra == i0_reg_dst)) ||
                                     (i1_use_rb && (i1_rb == i0_reg_dst)) ||
                                     (i1_use_rc && (i1_rc == i0_reg_dst)));
  assign waw      = i0_reg_wr && i1_reg_wr && (i0_reg_dst == i1_reg_dst);
  assign conflict = (i0_pipe == i1_pipe) || i1_reads_i0 || waw;

  assign s0 = '{valid: 1'b1, full_instr: i0_full_instr, reg_wr: i0_reg_wr, reg_dst: i0_reg_dst,
                latency: i0_latency, ra: i0_ra, rb: i0_rb, rc: i0_rc};
  assign s1 = '{valid: 1'b1, full_instr: i1_full_instr, reg_wr: i1_reg_wr, reg_dst: i1_reg_dst,
                latency: i1_latency, ra: i1_ra, rb: i1_rb, rc: i1_rc};

  always_comb begin
    iss0      = 1'b0;
    iss1      = 1'b0;
    pair_done = 1'b0;
    state_d   = state_q;
    ev_d      = '0;
    od_d      = '0;
    if (flush) begin
      state_d = StIdle;
    end else if (in_valid) begin
      unique case (state_q)
        StIdle: begin
          if (i0_rdy) begin
            iss0 = 1'b1;
            if (!conflict && i1_rdy) begin
              iss1      = 1'b1;
              pair_done = 1'b1;
            end else begin
              state_d = StSecond;
            end
          end
        end
        StSecond: begin
          if (i1_rdy) begin
            iss1      = 1'b1;
            pair_done = 1'b1;
            state_d   = StIdle;
          end
        end
        default: ;
      endcase
    end
    if (iss0) begin
      if (i0_pipe == PIPE_ODD) od_d = s0;
      else                     ev_d = s0;
    end
    if (iss1) begin
      if (i1_pipe == PIPE_ODD) od_d = s1;
      else                     ev_d = s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ev_q    <= '0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      ev_q    <= ev_d;
      od_q    <= od_d;
    end
  end

  // Combinational: the pair is consumed at the coming edge (last issue or flush).
  assign in_ready = !rst && (flush || pair_done);

  assign ev_valid      = ev_q.valid;
  assign ev_full_instr = ev_q.full_instr;
  assign ev_reg_wr     = ev_q.reg_wr;
  assign ev_reg_dst    = ev_q.reg_dst;
  assign ev_latency    = ev_q.latency;
  assign ev_ra         = ev_q.ra;
  assign ev_rb         = ev_q.rb;
  assign ev_rc         = ev_q.rc;
  assign od_valid      = od_q.valid;
  assign od_full_instr = od_q.full_instr;
  assign od_reg_wr     = od_q.reg_wr;
  assign od_reg_dst    = od_q.reg_dst;
  assign od_latency    = od_q.latency;
  assign od_ra         = od_q.ra;
  assign od_rb         = od_q.rb;
  assign od_rc         = od_q.rc;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: directed scenarios then random pairs, checked against a model that
// tracks the cycle at which each register's result becomes readable.
module tb_dual_issue_ctrl;
  import dual_issue_ctrl_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic        pipe;
    logic        wr;
    logic [6:0]  dst;
    logic [3:0]  lat;
    logic [6:0]  ra, rb, rc;
    logic        ua, ub, uc;
  } inst_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush;
  logic [31:0] i0_full_instr, i1_full_instr, ev_full_instr, od_full_instr;
  logic i0_pipe, i0_reg_wr, i0_use_ra, i0_use_rb, i0_use_rc;
  logic i1_pipe, i1_reg_wr, i1_use_ra, i1_use_rb, i1_use_rc;
  logic [6:0] i0_reg_dst, i0_ra, i0_rb, i0_rc, i1_reg_dst, i1_ra, i1_rb, i1_rc;
  logic [3:0] i0_latency, i1_latency, ev_latency, od_latency;
  logic ev_valid, ev_reg_wr, od_valid, od_reg_wr;
  logic [6:0] ev_reg_dst, ev_ra, ev_rb, ev_rc, od_reg_dst, od_ra, od_rb, od_rc;

  int    checks = 0;
  int    errors = 0;
  int    t;             // model cycle index
  int    avail [128];   // first cycle at which each register may be read
  bit    i0_done;       // older instruction of the held pair already issued
  bit    last_rdy;
  inst_t p0, p1, nop;

  always #5 clk = ~clk;

  dual_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .i0_full_instr(i0_full_instr), .i0_pipe(i0_pipe), .i0_reg_wr(i0_reg_wr),
    .i0_reg_dst(i0_reg_dst), .i0_latency(i0_latency), .i0_ra(i0_ra), .i0_rb(i0_rb),
    .i0_rc(i0_rc), .i0_use_ra(i0_use_ra), .i0_use_rb(i0_use_rb), .i0_use_rc(i0_use_rc),
    .i1_full_instr(i1_full_instr), .i1_pipe(i1_pipe), .i1_reg_wr(i1_reg_wr),
    .i1_reg_dst(i1_reg_dst), .i1_latency(i1_latency), .i1_ra(i1_ra), .i1_rb(i1_rb),
    .i1_rc(i1_rc), .i1_use_ra(i1_use_ra), .i1_use_rb(i1_use_rb), .i1_use_rc(i1_use_rc),
    .ev_valid(ev_valid), .ev_full_instr(ev_full_instr), .ev_reg_wr(ev_reg_wr),
    .ev_reg_dst(ev_reg_dst), .ev_latency(ev_latency), .ev_ra(ev_ra), .ev_rb(ev_rb),
    .ev_rc(ev_rc), .od_valid(od_valid), .od_full_instr(od_full_instr), .od_reg_wr(od_reg_wr),
    .od_reg_dst(od_reg_dst), .od_latency(od_latency), .od_ra(od_ra), .od_rb(od_rb),
    .od_rc(od_rc)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic inst_t mk(input logic [31:0] instr, input logic pipe, input logic wr,
                               input int dst, input int lat, input int ra, input int rb,
                               input int rc, input logic [2:0] use_abc);
    inst_t x;
    x.instr = instr; x.pipe = pipe; x.wr = wr; x.dst = 7'(dst); x.lat = 4'(lat);
    x.ra = 7'(ra); x.rb = 7'(rb); x.rc = 7'(rc);
    x.ua = use_abc[2]; x.ub = use_abc[1]; x.uc = use_abc[0];
    return x;
  endfunction

  function automatic inst_t rnd_inst();
    inst_t x;
    x.instr = $urandom; x.pipe = 1'($urandom); x.wr = 1'($urandom);
    x.dst = 7'($urandom_range(0, 7)); x.lat = 4'($urandom_range(1, 7));
    x.ra = 7'($urandom_range(0, 7)); x.rb = 7'($urandom_range(0, 7));
    x.rc = 7'($urandom_range(0, 7));
    x.ua = 1'($urandom); x.ub = 1'($urandom); x.uc = 1'($urandom);
    return x;
  endfunction

  function automatic logic [65:0] slot_of(input inst_t x);
    return {1'b1, x.instr, x.wr, x.dst, x.lat, x.ra, x.rb, x.rc};
  endfunction

  function automatic bit src_ok(input inst_t x);
    bit ok;
    ok = 1'b1;
    if (x.ua && avail[x.ra] > t) ok = 1'b0;
    if (x.ub && avail[x.rb] > t) ok = 1'b0;
    if (x.uc && avail[x.rc] > t) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit hazard(input inst_t a, input inst_t b);
    bit raw;
    raw = a.wr && ((b.ua && b.ra == a.dst) || (b.ub && b.rb == a.dst) ||
                   (b.uc && b.rc == a.dst));
    return (a.pipe == b.pipe) || raw || (a.wr && b.wr && a.dst == b.dst);
  endfunction

  function automatic void note_write(input inst_t x);
    if (x.wr && avail[x.dst] < t + int'(x.lat)) avail[x.dst] = t + int'(x.lat);
  endfunction

  task automatic present(input inst_t a, input inst_t b);
    p0 = a; p1 = b;
    i0_full_instr = a.instr; i0_pipe = a.pipe; i0_reg_wr = a.wr; i0_reg_dst = a.dst;
    i0_latency = a.lat; i0_ra = a.ra; i0_rb = a.rb; i0_rc = a.rc;
    i0_use_ra = a.ua; i0_use_rb = a.ub; i0_use_rc = a.uc;
    i1_full_instr = b.instr; i1_pipe = b.pipe; i1_reg_wr = b.wr; i1_reg_dst = b.dst;
    i1_latency = b.lat; i1_ra = b.ra; i1_rb = b.rb; i1_rc = b.rc;
    i1_use_ra = b.ua; i1_use_rb = b.ub; i1_use_rc = b.uc;
  endtask

  // One clock: predict, check in_ready before the edge, check slots and counters after it.
  task automatic step();
    logic [65:0]  e_ev, e_od, o_ev, o_od;
    logic [511:0] e_cnt, o_cnt;
    logic         e_rdy;
    bit           r0, r1;
    int           v;
    #1;
    e_ev = '0; e_od = '0; e_rdy = 1'b0;
    if (rst) begin
      for (int r = 0; r < 128; r++) avail[r] = 0;
      i0_done = 1'b0;
    end else if (flush) begin
      e_rdy = 1'b1; i0_done = 1'b0;
    end else if (in_valid) begin
      r0 = src_ok(p0); r1 = src_ok(p1);
      if (!i0_done && r0) begin
        if (p0.pipe) e_od = slot_of(p0); else e_ev = slot_of(p0);
        note_write(p0);
        if (!hazard(p0, p1) && r1) begin
          if (p1.pipe) e_od = slot_of(p1); else e_ev = slot_of(p1);
          note_write(p1);
          e_rdy = 1'b1;
        end else begin
          i0_done = 1'b1;
        end
      end else if (i0_done && r1) begin
        if (p1.pipe) e_od = slot_of(p1); else e_ev = slot_of(p1);
        note_write(p1);
        e_rdy = 1'b1; i0_done = 1'b0;
      end
    end
    chk("in_ready", in_ready, e_rdy);
    for (int r = 0; r < 128; r++) begin
      v = avail[r] - (t + 1);
      e_cnt[r*4 +: 4] = (v > 0) ? 4'(v) : 4'd0;
    end
    @(posedge clk);
    #1;
    o_ev = {ev_valid, ev_full_instr, ev_reg_wr, ev_reg_dst, ev_latency, ev_ra, ev_rb, ev_rc};
    o_od = {od_valid, od_full_instr, od_reg_wr, od_reg_dst, od_latency, od_ra, od_rb, od_rc};
    for (int r = 0; r < 128; r++) o_cnt[r*4 +: 4] = dut.u_sb.cnt_q[r];
    chk("ev_slot", o_ev, e_ev);
    chk("od_slot", o_od, e_od);
    chk("scoreboard", o_cnt, e_cnt);
    t++;
    last_rdy = e_rdy;
    @(negedge clk);
  endtask

  initial begin
    nop = '0;
    t = 0; i0_done = 1'b0; last_rdy = 1'b0;
    for (int r = 0; r < 128; r++) avail[r] = 0;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    present(nop, nop);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();

    // Independent pair: even add r3<-r1,r2 (lat 2), odd load r5<-r4 (lat 6).
    in_valid = 1'b1;
    present(mk(32'h002081b3, PIPE_EVEN, 1, 3, 2, 1, 2, 0, 3'b110),
            mk(32'h00022283, PIPE_ODD, 1, 5, 6, 4, 0, 0, 3'b100));
    step();
    chk("t1_both_valid", {ev_valid, od_valid}, 2'b11);
    chk("t1_cnt3", dut.u_sb.cnt_q[3], 4'd1);
    chk("t1_cnt5", dut.u_sb.cnt_q[5], 4'd5);
    in_valid = 1'b0;
    step();

    // Structural conflict: both even.
    in_valid = 1'b1;
    present(mk(32'h11111111, PIPE_EVEN, 1, 10, 1, 11, 0, 0, 3'b100),
            mk(32'h22222222, PIPE_EVEN, 1, 12, 3, 13, 0, 0, 3'b100));
    step();
    chk("t2_c1_slots", {ev_valid, od_valid, ev_full_instr}, {2'b10, 32'h11111111});
    step();
    chk("t2_c2_slots", {ev_valid, od_valid, ev_full_instr}, {2'b10, 32'h22222222});

    // In-flight producer r7 (lat 6), then a consumer stalls five cycles.
    present(mk(32'h33333333, PIPE_EVEN, 1, 7, 6, 0, 0, 0, 3'b000),
            mk(32'h44444444, PIPE_ODD, 0, 0, 1, 0, 0, 0, 3'b000));
    step();
    chk("t3_cnt7_start", dut.u_sb.cnt_q[7], 4'd5);
    present(mk(32'h55555555, PIPE_EVEN, 0, 0, 1, 7, 0, 0, 3'b100),
            mk(32'h66666666, PIPE_ODD, 0, 0, 1, 0, 0, 0, 3'b000));
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t3_stall_nop", {ev_valid, od_valid}, 2'b00);
      chk("t3_cnt7", dut.u_sb.cnt_q[7], 4'(5 - k));
    end
    step();
    chk("t3_issue", {ev_valid, od_valid}, 2'b11);

    // Intra-pair RAW on r9: split, then i1 waits for the counter.
    present(mk(32'h77777777, PIPE_ODD, 1, 9, 3, 0, 0, 0, 3'b000),
            mk(32'h88888888, PIPE_EVEN, 0, 0, 1, 9, 0, 0, 3'b100));
    step();
    chk("t4_i0_only", {ev_valid, od_valid}, 2'b01);
    step();
    step();
    chk("t4_wait", {ev_valid, od_valid, dut.u_sb.cnt_q[9]}, {2'b00, 4'd0});
    step();
    chk("t4_i1_issue", {ev_valid, od_valid, ev_full_instr}, {2'b10, 32'h88888888});

    // Flush while the second instruction is pending; flush beats the issue.
    present(mk(32'h99999999, PIPE_EVEN, 1, 20, 5, 0, 0, 0, 3'b000),
            mk(32'haaaaaaaa, PIPE_EVEN, 0, 0, 1, 0, 0, 0, 3'b000));
    step();
    chk("t5_in_second", dut.state_q, StSecond);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_flush", {ev_valid, od_valid, dut.u_sb.cnt_q[20]}, {2'b00, 4'd3});
    chk("t5_idle", dut.state_q, StIdle);
    present(mk(32'hbbbbbbbb, PIPE_ODD, 0, 0, 1, 0, 0, 0, 3'b000),
            mk(32'hcccccccc, PIPE_EVEN, 0, 0, 1, 0, 0, 0, 3'b000));
    step();

    // Reset in the middle of a stall on r7.
    present(mk(32'hdddddddd, PIPE_EVEN, 1, 7, 6, 0, 0, 0, 3'b000),
            mk(32'heeeeeeee, PIPE_ODD, 0, 0, 1, 0, 0, 0, 3'b000));
    step();
    present(mk(32'h12345678, PIPE_ODD, 0, 0, 1, 7, 0, 0, 3'b100),
            mk(32'h9abcdef0, PIPE_EVEN, 0, 0, 1, 0, 0, 0, 3'b000));
    step();
    step();
    chk("t6_cnt7_pre", dut.u_sb.cnt_q[7], 4'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_after_rst", {ev_valid, od_valid, dut.u_sb.cnt_q[7]}, {2'b00, 4'd0});
    step();
    chk("t6_reissue", {ev_valid, od_valid}, 2'b11);

    // Random pairs, held until consumed.
    repeat (400) begin
      if (last_rdy) present(rnd_inst(), rnd_inst());
      in_valid = ($urandom_range(0, 7) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
